// File: rtl/rat_cp_ctrl_pkg.sv
// Shared sizing defaults and types for the RAT checkpoint scheduler.
// Defaults mirror RENAME_WIDTH / RAT_CP_SIZE / RAT_CP_INDEX_SIZE of the core header.
package rat_cp_ctrl_pkg;

  localparam int unsigned DEF_RENAME_WIDTH = 4;
  localparam int unsigned DEF_CP_SIZE      = 8;
  localparam int unsigned DEF_CP_IDX       = 3;

  typedef logic [DEF_CP_IDX-1:0] rat_cp_tag_t;

endpackage

// File: rtl/rat_cp_ctrl_if.sv
// Rename-group allocation bundle between group decode (master) and the checkpoint scheduler (slave).
interface rat_cp_ctrl_if
  import rat_cp_ctrl_pkg::*;
#(
  parameter int unsigned RENAME_WIDTH = DEF_RENAME_WIDTH,
  parameter int unsigned CP_IDX       = DEF_CP_IDX
);
  logic                           pause;
  logic [RENAME_WIDTH-1:0]        br_req;
  logic                           cp_grant;
  logic [RENAME_WIDTH*CP_IDX-1:0] cp_tag;
  logic                           cp_stall;

  modport master (
    output pause, br_req,
    input  cp_grant, cp_tag, cp_stall
  );

  modport slave (
    input  pause, br_req,
    output cp_grant, cp_tag, cp_stall
  );
endinterface

// File: rtl/rat_cp_ctrl_prefix.sv
// Exclusive prefix popcount of the branch-request vector: per-slot offset and group total.
module rat_cp_prefix #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic [WIDTH-1:0]       req_i,
  output logic [WIDTH*CNT_W-1:0] offset_o,
  output logic [CNT_W-1:0]       total_o
);
  logic [CNT_W-1:0] acc;

  always_comb begin
    acc      = '0;
    offset_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      offset_o[i*CNT_W +: CNT_W] = acc;
      acc = acc + CNT_W'(req_i[i]);
    end
    total_o = acc;
  end
endmodule

// File: rtl/rat_cp_ctrl.sv
// RAT checkpoint scheduler: circular slot queue, all-or-nothing group allocation, rollback on mispredict.
// Optional stall/peak statistics are built only when RAT_CP_STATS_EN is defined.
module rat_cp_ctrl
  import rat_cp_ctrl_pkg::*;
#(
  parameter int unsigned RENAME_WIDTH = DEF_RENAME_WIDTH,
  parameter int unsigned CP_SIZE      = DEF_CP_SIZE,
  parameter int unsigned CP_IDX       = DEF_CP_IDX
) (
  input  logic              clock,
  input  logic              reset,
  rat_cp_ctrl_if.slave      alloc,
  input  logic              free_valid,
  input  logic              recover,
  input  logic [CP_IDX-1:0] recover_tag,
  output logic              restore_valid,
  output logic [CP_IDX-1:0] restore_tag,
  output logic              checkable,
  output logic [CP_IDX:0]   occupancy,
  output logic [31:0]       stat_stalls,
  output logic [CP_IDX:0]   stat_peak
);
  localparam int unsigned CW = CP_IDX + 1;
  localparam int unsigned NW = $clog2(RENAME_WIDTH + 1);

  logic [CP_IDX-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CP_IDX-1:0]          restore_tag_q, restore_tag_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       restore_valid_q, restore_valid_d;
  logic                       checkable_q, checkable_d;

  logic [RENAME_WIDTH*NW-1:0] offset;
  logic [NW-1:0]              n_req;
  logic                       has_req, fits, grant, stall, do_free;
  logic [CP_IDX-1:0]          rec_span, rec_dist;

  rat_cp_prefix #(
    .WIDTH (RENAME_WIDTH),
    .CNT_W (NW)
  ) u_prefix (
    .req_i    (alloc.br_req),
    .offset_o (offset),
    .total_o  (n_req)
  );

  // Room is judged on the pre-free count; a same-cycle commit never enables a grant.
  assign has_req = (n_req != '0);
  assign fits    = (CP_SIZE - 32'(count_q)) >= 32'(n_req);
  assign grant   = !reset && !alloc.pause && !recover && fits;
  assign stall   = has_req && !grant && !alloc.pause && !recover;
  assign do_free = free_valid && (count_q != '0);

  assign alloc.cp_grant = grant && has_req;
  assign alloc.cp_stall = stall;

  always_comb begin
    alloc.cp_tag = '0;
    for (int unsigned i = 0; i < RENAME_WIDTH; i++) begin
      alloc.cp_tag[i*CP_IDX +: CP_IDX] = tail_q + CP_IDX'(offset[i*NW +: NW]);
    end
  end

  // Ring distance wraps naturally in CP_IDX bits; a full ring recovered at head yields zero.
  assign rec_span = recover_tag - head_q;
  assign rec_dist = rec_span - CP_IDX'(do_free);

  always_comb begin
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    restore_valid_d = 1'b0;
    restore_tag_d   = restore_tag_q;
    if (recover) begin
      tail_d          = recover_tag;
      count_d         = {1'b0, rec_dist};
      restore_valid_d = 1'b1;
      restore_tag_d   = recover_tag;
      if (do_free) begin
        head_d = head_q + CP_IDX'(1);
      end
    end else begin
      if (grant) begin
        tail_d = tail_q + CP_IDX'(n_req);
      end
      if (do_free) begin
        head_d = head_q + CP_IDX'(1);
      end
      count_d = count_q + (grant ? CW'(n_req) : '0) - CW'(do_free);
    end
    checkable_d = 32'(count_d) < CP_SIZE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      restore_valid_q <= 1'b0;
      restore_tag_q   <= '0;
      checkable_q     <= 1'b1;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      restore_valid_q <= restore_valid_d;
      restore_tag_q   <= restore_tag_d;
      checkable_q     <= checkable_d;
    end
  end

  assign restore_valid = restore_valid_q;
  assign restore_tag   = restore_tag_q;
  assign checkable     = checkable_q;
  assign occupancy     = count_q;

`ifdef RAT_CP_STATS_EN
  logic [31:0]   stalls_q;
  logic [CW-1:0] peak_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stalls_q <= '0;
      peak_q   <= '0;
    end else begin
      if (stall && (stalls_q != '1)) begin
        stalls_q <= stalls_q + 32'd1;
      end
      if (count_d > peak_q) begin
        peak_q <= count_d;
      end
    end
  end

  assign stat_stalls = stalls_q;
  assign stat_peak   = peak_q;
`else
  assign stat_stalls = '0;
  assign stat_peak   = '0;
`endif

  a_free_live: assert property (@(posedge clock) disable iff (reset)
    free_valid |-> (count_q != '0))
    else $error("free_valid with no live checkpoint");

  a_recover_range: assert property (@(posedge clock) disable iff (reset)
    recover |-> ({1'b0, rec_span} < count_q))
    else $error("recover_tag outside [head, tail)");

  a_recover_free: assert property (@(posedge clock) disable iff (reset)
    (recover && free_valid) |-> (recover_tag != head_q))
    else $error("recover of the committing checkpoint");
endmodule

// File: tb/tb_rat_cp_ctrl.sv
// Directed and randomized bench for rat_cp_ctrl against a queue-of-live-tags reference model.
module tb_rat_cp_ctrl;
  localparam int RW      = 4;
  localparam int CP_SIZE = 8;
  localparam int IDX     = 3;

  logic           clock;
  logic           reset;
  logic           free_valid;
  logic           recover;
  logic [IDX-1:0] recover_tag;
  logic           restore_valid;
  logic [IDX-1:0] restore_tag;
  logic           checkable;
  logic [IDX:0]   occupancy;
  logic [31:0]    stat_stalls;
  logic [IDX:0]   stat_peak;

  rat_cp_ctrl_if #(.RENAME_WIDTH(RW), .CP_IDX(IDX)) bus ();

  rat_cp_ctrl #(
    .RENAME_WIDTH (RW),
    .CP_SIZE      (CP_SIZE),
    .CP_IDX       (IDX)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .alloc         (bus),
    .free_valid    (free_valid),
    .recover       (recover),
    .recover_tag   (recover_tag),
    .restore_valid (restore_valid),
    .restore_tag   (restore_tag),
    .checkable     (checkable),
    .occupancy     (occupancy),
    .stat_stalls   (stat_stalls),
    .stat_peak     (stat_peak)
  );

  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: live checkpoints oldest-first, next free tag, stats.
  int live[$];
  int tail_m  = 0;
  bit rv_m    = 0;
  int rt_m    = 0;
  int stall_m = 0;
  int peak_m  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic [3:0] br, input bit pz, input bit fv, input bit rc,
                       input int rt, input bit rs);
    int n, k;
    bit g, st;
    reset       = rs;
    bus.br_req  = br;
    bus.pause   = pz;
    free_valid  = fv;
    recover     = rc;
    recover_tag = IDX'(rt);
    @(negedge clock);
    n  = $countones(br);
    g  = !rs && !pz && !rc && ((CP_SIZE - live.size()) >= n);
    st = (n != 0) && !g && !pz && !rc;
    chk("cp_grant", 32'(bus.cp_grant), 32'(g && (n != 0)));
    chk("cp_stall", 32'(bus.cp_stall), 32'(st));
    if (g) begin
      k = 0;
      for (int i = 0; i < RW; i++) begin
        if (br[i]) begin
          chk($sformatf("cp_tag[%0d]", i), 32'(bus.cp_tag[i*IDX +: IDX]), 32'((tail_m + k) % CP_SIZE));
          k++;
        end
      end
    end
    if (rs) begin
      live.delete();
      tail_m = 0; rv_m = 0; rt_m = 0; stall_m = 0; peak_m = 0;
    end else begin
      if (st) stall_m++;
      if (rc) begin
        if (fv) void'(live.pop_front());
        while (live.size() > 0 && live[$] != rt) void'(live.pop_back());
        if (live.size() > 0) void'(live.pop_back());
        tail_m = rt; rv_m = 1; rt_m = rt;
      end else begin
        rv_m = 0;
        if (g) begin
          for (int i = 0; i < n; i++) begin
            live.push_back(tail_m);
            tail_m = (tail_m + 1) % CP_SIZE;
          end
        end
        if (fv && live.size() > 0) void'(live.pop_front());
      end
      if (live.size() > peak_m) peak_m = live.size();
    end
    @(posedge clock);
    #1;
    chk("occupancy", 32'(occupancy), 32'(live.size()));
    chk("checkable", 32'(checkable), 32'(live.size() < CP_SIZE));
    chk("restore_valid", 32'(restore_valid), 32'(rv_m));
    if (rv_m || rs) chk("restore_tag", 32'(restore_tag), 32'(rt_m));
`ifdef RAT_CP_STATS_EN
    chk("stat_stalls", stat_stalls, 32'(stall_m));
    chk("stat_peak", 32'(stat_peak), 32'(peak_m));
`else
    chk("stat_stalls", stat_stalls, 32'd0);
    chk("stat_peak", 32'(stat_peak), 32'd0);
`endif
  endtask

  initial begin
    logic [3:0] br;
    bit pz, fv, rc, rs;
    int rt;

    cycle(4'b0000, 0, 0, 0, 0, 1);
    cycle(4'b0000, 0, 0, 0, 0, 1);

    // Basic allocation, then the next group starts at tail 2.
    cycle(4'b0101, 0, 0, 0, 0, 0);
    cycle(4'b0001, 0, 0, 0, 0, 0);
    // Fill to seven; a two-branch group stalls, even with a commit alongside.
    cycle(4'b1111, 0, 0, 0, 0, 0);
    cycle(4'b0011, 0, 0, 0, 0, 0);
    cycle(4'b0011, 0, 1, 0, 0, 0);

    // head=6, tail=1, three live; recover to 7.
    cycle(4'b0000, 0, 0, 0, 0, 1);
    cycle(4'b1111, 0, 0, 0, 0, 0);
    cycle(4'b0011, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(4'b0000, 0, 1, 0, 0, 0);
    cycle(4'b0111, 0, 0, 0, 0, 0);
    cycle(4'b0000, 0, 0, 1, 7, 0);
    cycle(4'b0000, 0, 0, 0, 0, 0);

    // Full ring with head=tail=2, stalls, then recover at head.
    cycle(4'b0000, 0, 1, 0, 0, 0);
    cycle(4'b0111, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(4'b0000, 0, 1, 0, 0, 0);
    cycle(4'b1111, 0, 0, 0, 0, 0);
    cycle(4'b1111, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(4'b0001, 0, 0, 0, 0, 0);
    cycle(4'b0000, 0, 0, 1, 2, 0);

    // Recover blocks a same-cycle group; pause blocks without stalling.
    cycle(4'b0011, 0, 0, 0, 0, 0);
    cycle(4'b1111, 0, 0, 1, 3, 0);
    cycle(4'b0001, 1, 0, 0, 0, 0);
    // Recover combined with a commit, then reset during a recover.
    cycle(4'b0111, 0, 0, 0, 0, 0);
    cycle(4'b0000, 0, 1, 1, 4, 0);
    cycle(4'b0000, 0, 0, 1, 2, 1);
    cycle(4'b0000, 0, 0, 0, 0, 0);

    for (int k = 0; k < 500; k++) begin
      br = 4'($urandom);
      pz = ($urandom_range(7) == 0);
      rs = ($urandom_range(149) == 0);
      fv = (live.size() > 0) && ($urandom_range(2) == 0);
      rc = 0;
      rt = 0;
      if ($urandom_range(6) == 0) begin
        if (fv && live.size() >= 2) begin
          rc = 1;
          rt = live[$urandom_range(live.size() - 1, 1)];
        end else if (!fv && live.size() > 0) begin
          rc = 1;
          rt = live[$urandom_range(live.size() - 1, 0)];
        end
      end
      cycle(br, pz, fv, rc, rt, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
